// File: rtl/xbar_eval_seq_pkg.sv
// Shared types and defaults for the crossbar evaluation sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package xbar_eval_seq_pkg;

  localparam int N_IN_DEF   = 4;
  localparam int N_REQ_DEF  = 2;
  localparam int SETTLE_DEF = 2;
  localparam int EVAL_CNT_W = 16;
  // Wide enough for SETTLE-1 with SETTLE up to 15.
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/xbar_eval_seq_rr_arb.sv
// Round-robin arbiter: picks the first active request after last_grant, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller qualifies the grant with its own state.
module rr_arb #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0] gnt_idx
);

  logic found;

  // Scan positions last_grant+1, +2, ... (mod N_REQ); the first active request wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req[i] && (i == ((int'(last_grant) + k) % N_REQ))) begin
          found     = 1'b1;
          gnt_oh[i] = 1'b1;
          gnt_idx   = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/xbar_eval_seq.sv
// Sequences one crossbar evaluation at a time for N_REQ requesters: drive, settle, sample, respond.
// Latency: transfer at cycle t -> xb_en in t+1..t+SETTLE+2, rsp_valid from t+SETTLE+3.
// Backpressure: response held stable until rsp_ready; new requests only accepted in IDLE.
module xbar_eval_seq
  import xbar_eval_seq_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int N_REQ  = N_REQ_DEF,
  parameter int SETTLE = SETTLE_DEF,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*N_IN-1:0]   req_vec,
  output logic                    xb_en,
  output logic [N_IN-1:0]         xb_in,
  input  logic                    xb_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_val,
  output logic                    busy,
  output logic [EVAL_CNT_W-1:0]   eval_cnt
);

  state_t                state_q, state_d;
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic [N_IN-1:0]       vec_q, vec_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rsp_val_q, rsp_val_d;
  logic [EVAL_CNT_W-1:0] eval_cnt_q, eval_cnt_d;

  logic [N_REQ-1:0]      gnt_oh;
  logic [ID_W-1:0]       gnt_idx;
  logic [N_IN-1:0]       sel_vec;

  rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (ID_W)
  ) u_rr_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .gnt_oh     (gnt_oh),
    .gnt_idx    (gnt_idx)
  );

  // Pick the granted requester's input vector out of the flattened bus.
  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_vec = req_vec[i*N_IN +: N_IN];
      end
    end
  end

  // Next-state and output decode; crossbar drive comes only from registered state.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    vec_d        = vec_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    rsp_val_d    = rsp_val_q;
    eval_cnt_d   = eval_cnt_q;
    req_ready    = '0;
    xb_en        = 1'b0;
    xb_in        = '0;
    rsp_valid    = 1'b0;
    busy         = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        req_ready = gnt_oh;
        if (|(req_valid & gnt_oh)) begin
          vec_d        = sel_vec;
          id_d         = gnt_idx;
          last_grant_d = gnt_idx;
          state_d      = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        xb_en   = 1'b1;
        xb_in   = vec_q;
        cnt_d   = CNT_W'(SETTLE - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        xb_en = 1'b1;
        xb_in = vec_q;
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        xb_en     = 1'b1;
        xb_in     = vec_q;
        rsp_val_d = xb_out;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
          if (eval_cnt_q != '1) begin
            eval_cnt_d = eval_cnt_q + EVAL_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rsp_id   = id_q;
  assign rsp_val  = rsp_val_q;
  assign eval_cnt = eval_cnt_q;

  // State registers; reset aborts any evaluation in flight and restarts arbitration at requester 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      vec_q        <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      rsp_val_q    <= 1'b0;
      eval_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      vec_q        <= vec_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      rsp_val_q    <= rsp_val_d;
      eval_cnt_q   <= eval_cnt_d;
    end
  end

endmodule

// File: tb/tb_xbar_eval_seq.sv
// Directed bench for xbar_eval_seq: table of evaluations plus hand-written corner sequences.
// Latency: checks exact cycle placement of xb_en and rsp_valid around each transfer.
// Backpressure: exercises rsp_ready held low in RESP and reset during SETTLE.
module tb_xbar_eval_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_vec;
  logic        xb_en;
  logic [3:0]  xb_in;
  logic        xb_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:0]  rsp_id;
  logic        rsp_val;
  logic        busy;
  logic [15:0] eval_cnt;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_cnt  = 16'd0;

  typedef struct packed {
    logic [1:0] valid;
    logic [3:0] v0;
    logic [3:0] v1;
    logic       xbo;
    logic       tog;
    logic       id;
    logic [3:0] vec;
    logic       val;
  } vec_t;

  vec_t tbl [9];

  xbar_eval_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vec   (req_vec),
    .xb_en     (xb_en),
    .xb_in     (xb_in),
    .xb_out    (xb_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_val   (rsp_val),
    .busy      (busy),
    .eval_cnt  (eval_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full evaluation starting in IDLE; req_valid stays asserted throughout to show it is ignored.
  task automatic run_eval(input vec_t r);
    logic [1:0] exp_rdy;
    exp_rdy   = 2'b01 << r.id;
    req_valid = r.valid;
    req_vec   = {r.v1, r.v0};
    xb_out    = r.xbo;
    rsp_ready = 1'b1;
    #1;
    chk("idle_busy", 32'(busy), 32'(1'b0));
    chk("grant_ready", 32'(req_ready), 32'(exp_rdy));
    step();
    for (int k = 0; k < 4; k++) begin
      xb_out = r.xbo ^ (r.tog & k[0]);
      chk("xb_en_active", 32'(xb_en), 32'(1'b1));
      chk("xb_in_held", 32'(xb_in), 32'(r.vec));
      chk("no_early_rsp", 32'(rsp_valid), 32'(1'b0));
      chk("ready_low_busy", 32'(req_ready), 32'(2'b00));
      step();
    end
    xb_out = r.xbo;
    chk("rsp_valid", 32'(rsp_valid), 32'(1'b1));
    chk("rsp_id", 32'(rsp_id), 32'(r.id));
    chk("rsp_val", 32'(rsp_val), 32'(r.val));
    chk("resp_xb_en", 32'(xb_en), 32'(1'b0));
    chk("resp_xb_in", 32'(xb_in), 32'(4'b0000));
    chk("resp_ready_low", 32'(req_ready), 32'(2'b00));
    step();
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    chk("back_idle", 32'(busy), 32'(1'b0));
    chk("rsp_dropped", 32'(rsp_valid), 32'(1'b0));
    chk("eval_cnt", 32'(eval_cnt), 32'(exp_cnt));
  endtask

  initial begin
    //            valid  v0       v1       xbo  tog  id   vec      val
    tbl[0] = '{2'b01, 4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b1};
    tbl[1] = '{2'b11, 4'b1010, 4'b0101, 1'b0, 1'b0, 1'b1, 4'b0101, 1'b0};
    tbl[2] = '{2'b11, 4'b1100, 4'b0110, 1'b1, 1'b0, 1'b0, 4'b1100, 1'b1};
    tbl[3] = '{2'b11, 4'b1111, 4'b1001, 1'b1, 1'b0, 1'b1, 4'b1001, 1'b1};
    tbl[4] = '{2'b11, 4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0};
    tbl[5] = '{2'b10, 4'b0111, 4'b1110, 1'b1, 1'b0, 1'b1, 4'b1110, 1'b1};
    tbl[6] = '{2'b10, 4'b0100, 4'b0010, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0};
    tbl[7] = '{2'b01, 4'b1000, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b1};
    tbl[8] = '{2'b11, 4'b0110, 4'b1101, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b0};

    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_vec   = 8'h00;
    xb_out    = 1'b0;
    rsp_ready = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_xb_en", 32'(xb_en), 32'(1'b0));
    chk("rst_xb_in", 32'(xb_in), 32'(4'b0000));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
    chk("rst_rsp_id", 32'(rsp_id), 32'(1'b0));
    chk("rst_rsp_val", 32'(rsp_val), 32'(1'b0));
    chk("rst_eval_cnt", 32'(eval_cnt), 32'(16'h0000));
    chk("rst_req_ready", 32'(req_ready), 32'(2'b00));
    rst_n = 1'b1;
    step();

    // Reset in the middle of SETTLE: evaluation vanishes, arbitration restarts at requester 0.
    req_valid = 2'b01;
    req_vec   = 8'h0B;
    rsp_ready = 1'b1;
    #1;
    chk("mid_grant0", 32'(req_ready), 32'(2'b01));
    step();
    req_valid = 2'b00;
    chk("mid_drive", 32'(xb_en), 32'(1'b1));
    step();
    chk("mid_settle", 32'(xb_en), 32'(1'b1));
    chk("mid_settle_busy", 32'(busy), 32'(1'b1));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'(1'b0));
    chk("mid_rst_xb_en", 32'(xb_en), 32'(1'b0));
    chk("mid_rst_xb_in", 32'(xb_in), 32'(4'b0000));
    for (int i = 0; i < 6; i++) begin
      chk("mid_rst_no_rsp", 32'(rsp_valid), 32'(1'b0));
      chk("mid_rst_cnt", 32'(eval_cnt), 32'(16'h0000));
      step();
    end
    req_valid = 2'b11;
    #1;
    chk("mid_rst_next_grant", 32'(req_ready), 32'(2'b01));
    req_valid = 2'b00;

    // Table: single request, alternating contention, wrap-around and sampling-point rows.
    for (int i = 0; i < 9; i++) begin
      run_eval(tbl[i]);
    end

    // Backpressure: response must stay frozen while rsp_ready is low.
    req_valid = 2'b11;
    req_vec   = {4'b0000, 4'b0110};
    xb_out    = 1'b1;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'(2'b01));
    step();
    for (int k = 0; k < 4; k++) begin
      chk("bp_xb_in", 32'(xb_in), 32'(4'b0110));
      step();
    end
    for (int k = 0; k < 10; k++) begin
      xb_out = ~xb_out;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'(1'b1));
      chk("bp_rsp_val", 32'(rsp_val), 32'(1'b1));
      chk("bp_rsp_id", 32'(rsp_id), 32'(1'b0));
      chk("bp_xb_en", 32'(xb_en), 32'(1'b0));
      chk("bp_req_ready", 32'(req_ready), 32'(2'b00));
      chk("bp_cnt_hold", 32'(eval_cnt), 32'(exp_cnt));
      step();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    step();
    exp_cnt = exp_cnt + 16'd1;
    chk("bp_done_idle", 32'(busy), 32'(1'b0));
    chk("bp_done_cnt", 32'(eval_cnt), 32'(exp_cnt));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_rsp_ready_noop", 32'(eval_cnt), 32'(exp_cnt));
      chk("idle_no_rsp", 32'(rsp_valid), 32'(1'b0));
    end

    // Saturation: preload just below the ceiling, then complete two evaluations.
    force dut.eval_cnt_q = 16'hFFFE;
    #1;
    release dut.eval_cnt_q;
    #1;
    exp_cnt = 16'hFFFE;
    chk("sat_preload", 32'(eval_cnt), 32'(16'hFFFE));
    run_eval('{2'b01, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b0});
    run_eval('{2'b10, 4'b0000, 4'b1011, 1'b1, 1'b0, 1'b1, 4'b1011, 1'b1});
    chk("sat_hold", 32'(eval_cnt), 32'(16'hFFFF));
    req_valid = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xbar_eval_seq.md
XBAR_EVAL_SEQ -- requirements
Module: xbar_eval_seq

Interface
REQ-001 SHALL have parameter N_IN, default 4: number of crossbar input literals (a,b,c,d).
REQ-002 SHALL have parameter N_REQ, default 2: number of requesters sharing the crossbar.
REQ-003 SHALL have parameter SETTLE, default 2, legal range 1..15: crossbar settle cycles.
REQ-004 Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
req_valid  input  N_REQ  per-requester evaluation request
req_ready  output  N_REQ  per-requester accept (one-hot or zero)
req_vec  input  N_REQ*N_IN  input vectors; requester i at bits [i*N_IN +: N_IN]
xb_en  output  1  crossbar evaluation enable (drives source row high)
xb_in  output  N_IN  literal values applied to crossbar
xb_out  input  1  sensed crossbar output f
rsp_valid  output  1  result available
rsp_ready  input  1  result consumed
rsp_id  output  clog2(N_REQ) (min 1)  requester index of result
rsp_val  output  1  sampled f
busy  output  1  high in any state except IDLE
eval_cnt  output  16  completed evaluations, saturating

Function
REQ-005 SHALL implement FSM states IDLE, DRIVE, SETTLE, SAMPLE, RESP.
REQ-006 IDLE: when any req_valid is high, SHALL grant exactly one requester by round-robin, searching from (last_grant+1) mod N_REQ upward.
REQ-007 req_ready[g] SHALL be high only in IDLE, combinationally, for the granted g; the transfer is req_valid[g]&req_ready[g].
REQ-008 On transfer, SHALL capture req_vec slice g and g, update last_grant to g, and go to DRIVE.
REQ-009 DRIVE: xb_en=1, xb_in=captured vector; exactly one cycle, then SETTLE with counter loaded to SETTLE-1.
REQ-010 SETTLE: xb_en=1, xb_in held; counter decrements each cycle; leaves to SAMPLE in the cycle the counter is 0 (SETTLE cycles total).
REQ-011 SAMPLE: xb_en=1; SHALL register xb_out into rsp_val and go to RESP.
REQ-012 RESP: xb_en=0, xb_in=0, rsp_valid=1; rsp_val and rsp_id SHALL stay stable until rsp_ready.
REQ-013 On rsp_valid&rsp_ready, SHALL return to IDLE, increment eval_cnt (saturating at 16'hFFFF), and not grant in that same cycle.
REQ-014 Latency: transfer in cycle t leads to xb_en high in cycles t+1..t+SETTLE+2 and rsp_valid first high in cycle t+SETTLE+3 (t+5 at default).
REQ-015 xb_in SHALL be 0 whenever xb_en is 0; xb_in SHALL not change while xb_en is 1.
REQ-016 req_valid changes outside IDLE SHALL be ignored; requests are not queued.
REQ-017 rsp_ready high with rsp_valid low SHALL have no effect.
REQ-018 xb_out SHALL be sampled only in SAMPLE.

Reset
REQ-019 With rst_n low at a clock edge, SHALL enter IDLE and clear: counter, captured vector, rsp_val, rsp_id, eval_cnt; last_grant SHALL be set to N_REQ-1 so requester 0 wins first.
REQ-020 Output values during/after reset: req_ready=0 until first post-reset IDLE evaluation, xb_en=0, xb_in=0, rsp_valid=0, busy=0.
REQ-021 Reset mid-operation (any state) SHALL abort the evaluation: no response, no eval_cnt increment.

Structure
REQ-022 A shared package SHALL hold the FSM state enum, the default N_IN/N_REQ/SETTLE constants, and the eval_cnt width (16).
REQ-023 Round-robin grant logic SHALL be a sub-module rr_arb (inputs: request vector, last_grant; output: one-hot grant plus index).
REQ-024 Controller SHALL be fully synchronous; the only combinational path from inputs to outputs is req_valid to req_ready.

Verification
REQ-025 Single request: req0 vec=4'b0011, xb_out tied 1, rsp_ready=1 -> xb_en high 4 cycles, rsp_valid at t+5, rsp_id=0, rsp_val=1, eval_cnt=1.
REQ-026 Contention: req0 and req1 held valid continuously -> grants alternate 0,1,0,1; four responses with ids 0,1,0,1.
REQ-027 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_val, rsp_id stable, xb_en=0, req_ready=0 throughout; single completion after release.
REQ-028 Sampling point: xb_out toggled each cycle -> rsp_val equals xb_out in the SAMPLE cycle only; xb_in constant while xb_en=1.
REQ-029 Reset mid-SETTLE: rst_n low one cycle -> next cycle IDLE, xb_en=0, no rsp_valid, eval_cnt unchanged at 0; next grant goes to req0.
REQ-030 Saturation: preset via 65535 completions (or forced) -> one more completion leaves eval_cnt=16'hFFFF.
